// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC generator.
//   redirect_kind_t : kind of redirect held in the pending buffer
//   fetch_state_t   : fetch FSM state encoding
//   pc_next_seq     : wrap-around sequential PC add (caller truncates to its width)
package pc_pkg;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BRANCH = 2'd1,
    FLUSH  = 2'd2
  } redirect_kind_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  localparam logic [31:0] PC_RESET_VEC_DEF = 32'h0000_0000;
  localparam int          PC_INC_DEF       = 4;

  // Widest PC the helper supports; callers cast the result down to ADDR_W,
  // which yields the modulo-2^ADDR_W wrap for free.
  localparam int PC_MAX_W = 64;

  function automatic logic [PC_MAX_W-1:0] pc_next_seq(
    input logic [PC_MAX_W-1:0] pc_cur,
    input logic [PC_MAX_W-1:0] inc
  );
    return pc_cur + inc;
  endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Instruction-fetch port between the PC generator and instruction memory.
//   pc         : fetch address
//   ce         : fetch enable
//   if_req_o   : fetch request
//   if_ack_i   : memory accepted the current request
//   misalign_o : current fetch address is not aligned
// master = PC generator side, slave = instruction memory side.
interface pc_fetch_gen_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc;
  logic              ce;
  logic              if_req_o;
  logic              if_ack_i;
  logic              misalign_o;

  modport master (
    output pc, ce, if_req_o, misalign_o,
    input  if_ack_i
  );

  modport slave (
    input  pc, ce, if_req_o, misalign_o,
    output if_ack_i
  );
endinterface

// File: rtl/pc_redirect_buf.sv
// Redirect buffer: holds one pending redirect captured while fetch is not
// advancing, and picks the redirect candidate for the current cycle.
//   clk, rst        : clock, asynchronous active-low reset
//   en              : capture enable (fetch FSM running)
//   adv             : fetch advances this cycle (consumes the candidate)
//   flush_i/_target : flush redirect request and vector
//   branch_flag_i/_target : branch redirect request and target
//   cand_valid/_target    : selected redirect for this cycle
//   pending_valid   : a buffered redirect is waiting
module pc_redirect_buf
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              adv,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              cand_valid,
  output logic [ADDR_W-1:0] cand_target,
  output logic              pending_valid
);

  redirect_kind_t    pend_kind_q;
  logic [ADDR_W-1:0] pend_target_q;

  // Live flush beats a buffered flush, which beats any branch; a live branch
  // is newer than a buffered one.
  always_comb begin
    cand_valid  = 1'b1;
    cand_target = '0;
    if (flush_i)                   cand_target = flush_target_i;
    else if (pend_kind_q == FLUSH) cand_target = pend_target_q;
    else if (branch_flag_i)        cand_target = branch_target_i;
    else if (pend_kind_q == BRANCH) cand_target = pend_target_q;
    else                           cand_valid  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_kind_q   <= NONE;
      pend_target_q <= '0;
    end else if (adv) begin
      pend_kind_q   <= NONE;
      pend_target_q <= '0;
    end else if (en) begin
      if (flush_i) begin
        pend_kind_q   <= FLUSH;
        pend_target_q <= flush_target_i;
      end else if (branch_flag_i && (pend_kind_q != FLUSH)) begin
        pend_kind_q   <= BRANCH;
        pend_target_q <= branch_target_i;
      end
    end
  end

  assign pending_valid = (pend_kind_q != NONE);

endmodule

// File: rtl/pc_fetch_gen.sv
// Fetch PC generator: produces the fetch address and enable, drives the
// req/ack handshake to instruction memory, and applies stall, branch and
// flush redirects (redirects arriving while fetch is blocked are buffered).
//   clk, rst           : clock, asynchronous active-low reset
//   stall_i            : hold PC and drop the fetch request
//   branch_flag_i/_target_i : branch redirect
//   flush_i/flush_target_i  : flush/exception redirect (highest priority)
//   fetch              : fetch port (pc, ce, if_req_o, if_ack_i, misalign_o)
//   redirect_pending_o : a buffered redirect is waiting
module pc_fetch_gen
  import pc_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = ADDR_W'(PC_RESET_VEC_DEF),
  parameter int                PC_INC     = PC_INC_DEF,
  parameter int                ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_target_i,
  pc_fetch_gen_if.master    fetch,
  output logic              redirect_pending_o
);

  fetch_state_t      state_q, state_d;
  logic              ce_run;
  logic              adv;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_seq;
  logic              cand_valid;
  logic [ADDR_W-1:0] cand_target;

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: IDLE leaves on the first edge out of reset; RUN is sticky
  always_comb begin
    state_d = state_q;
    if (state_q == ST_IDLE) state_d = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    ce_run = (state_q == ST_RUN);
  end

  // ce is low in IDLE, so inputs (including ack) have no effect there
  assign adv = ce_run & ~stall_i & fetch.if_ack_i;

  assign pc_seq = ADDR_W'(pc_next_seq(PC_MAX_W'(pc_q), PC_MAX_W'(PC_INC)));

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk             (clk),
    .rst             (rst),
    .en              (ce_run),
    .adv             (adv),
    .flush_i         (flush_i),
    .flush_target_i  (flush_target_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .cand_valid      (cand_valid),
    .cand_target     (cand_target),
    .pending_valid   (redirect_pending_o)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     pc_q <= RESET_VEC;
    else if (adv) pc_q <= cand_valid ? cand_target : pc_seq;
  end

  assign fetch.pc         = pc_q;
  assign fetch.ce         = ce_run;
  assign fetch.if_req_o   = ce_run & ~stall_i;
  assign fetch.misalign_o = ce_run & (|pc_q[ALIGN_BITS-1:0]);

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen with hand-computed expected values.
module tb_pc_fetch_gen;
  import pc_pkg::*;

  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall_i = 1'b0;
  logic              branch_flag_i = 1'b0;
  logic [ADDR_W-1:0] branch_target_i = '0;
  logic              flush_i = 1'b0;
  logic [ADDR_W-1:0] flush_target_i = '0;
  logic              redirect_pending_o;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_gen_if #(.ADDR_W(ADDR_W)) fif ();

  pc_fetch_gen #(
    .ADDR_W     (ADDR_W),
    .RESET_VEC  (32'h0000_0000),
    .PC_INC     (4),
    .ALIGN_BITS (2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .stall_i            (stall_i),
    .branch_flag_i      (branch_flag_i),
    .branch_target_i    (branch_target_i),
    .flush_i            (flush_i),
    .flush_target_i     (flush_target_i),
    .fetch              (fif.master),
    .redirect_pending_o (redirect_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [31:0] epc, input logic ece,
                             input logic ereq, input logic epend);
    check({tag, ".pc"},   64'(fif.pc), 64'(epc));
    check({tag, ".ce"},   64'(fif.ce), 64'(ece));
    check({tag, ".req"},  64'(fif.if_req_o), 64'(ereq));
    check({tag, ".pend"}, 64'(redirect_pending_o), 64'(epend));
  endtask

  initial begin
    fif.if_ack_i = 1'b1;
    #1 rst = 1'b0;
    tick(); tick();
    check_state("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    check("reset.mis", 64'(fif.misalign_o), 64'd0);

    // Reset release: one IDLE cycle, then sequential fetch
    rst = 1'b1;
    #1 check_state("idle", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check_state("run0", 32'h0, 1'b1, 1'b1, 1'b0);
    tick(); check_state("run4", 32'h4, 1'b1, 1'b1, 1'b0);
    tick(); check_state("run8", 32'h8, 1'b1, 1'b1, 1'b0);
    tick(); check_state("runc", 32'hC, 1'b1, 1'b1, 1'b0);
    tick(); check_state("run10", 32'h10, 1'b1, 1'b1, 1'b0);

    // Stall for three edges
    stall_i = 1'b1;
    #1 check("stall.req", 64'(fif.if_req_o), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); check_state("stall", 32'h10, 1'b1, 1'b0, 1'b0);
    end
    stall_i = 1'b0;
    tick(); check_state("unstall", 32'h14, 1'b1, 1'b1, 1'b0);

    // Branch while ack low is buffered, taken after ack returns
    fif.if_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h200;
    tick(); check_state("br.cap", 32'h14, 1'b1, 1'b1, 1'b1);
    branch_flag_i = 1'b0; branch_target_i = 32'h0;
    tick(); check_state("br.wait", 32'h14, 1'b1, 1'b1, 1'b1);
    fif.if_ack_i = 1'b1;
    tick(); check_state("br.take", 32'h200, 1'b1, 1'b1, 1'b0);

    // Pending branch overwritten by flush; later branch ignored
    fif.if_ack_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h220;
    tick(); check_state("fl.br", 32'h200, 1'b1, 1'b1, 1'b1);
    branch_flag_i = 1'b0; flush_i = 1'b1; flush_target_i = 32'h180;
    tick(); check_state("fl.cap", 32'h200, 1'b1, 1'b1, 1'b1);
    flush_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h300;
    tick(); check_state("fl.nobr", 32'h200, 1'b1, 1'b1, 1'b1);
    branch_flag_i = 1'b0; fif.if_ack_i = 1'b1;
    tick(); check_state("fl.take", 32'h180, 1'b1, 1'b1, 1'b0);

    // Same-cycle flush and branch on an advance: flush wins
    flush_i = 1'b1; flush_target_i = 32'h400;
    branch_flag_i = 1'b1; branch_target_i = 32'h500;
    tick(); check_state("both", 32'h400, 1'b1, 1'b1, 1'b0);
    flush_i = 1'b0;

    // Wrap-around
    branch_target_i = 32'hFFFF_FFFC;
    tick(); check_state("wrap.pre", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
    check("wrap.mis", 64'(fif.misalign_o), 64'd0);
    branch_flag_i = 1'b0;
    tick(); check_state("wrap", 32'h0, 1'b1, 1'b1, 1'b0);

    // Misaligned target used as-is
    branch_flag_i = 1'b1; branch_target_i = 32'h102;
    tick(); check_state("mis", 32'h102, 1'b1, 1'b1, 1'b0);
    check("mis.flag", 64'(fif.misalign_o), 64'd1);
    branch_flag_i = 1'b0;
    tick(); check_state("mis.seq", 32'h106, 1'b1, 1'b1, 1'b0);
    check("mis.flag2", 64'(fif.misalign_o), 64'd1);

    // Async reset mid-wait with a pending flush
    fif.if_ack_i = 1'b0; flush_i = 1'b1; flush_target_i = 32'h800;
    tick(); check_state("rst.pend", 32'h106, 1'b1, 1'b1, 1'b1);
    flush_i = 1'b0;
    #2 rst = 1'b0;
    #1 check_state("rst.async", 32'h0, 1'b0, 1'b0, 1'b0);
    check("rst.mis", 64'(fif.misalign_o), 64'd0);
    tick(); tick();
    fif.if_ack_i = 1'b1; rst = 1'b1;
    #1 check_state("rst.idle", 32'h0, 1'b0, 1'b0, 1'b0);
    tick(); check_state("rst.run0", 32'h0, 1'b1, 1'b1, 1'b0);
    tick(); check_state("rst.run4", 32'h4, 1'b1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
